// File: rtl/fft_state2_if.sv
// Stream bundle between fft_state1 and fft_state2: two complex input lanes in,
// two complex butterfly lanes plus half/index tags out.
interface fft_state2_if #(
   parameter int WIDTH = 9
);
   logic                    in_valid;
   logic signed [WIDTH-1:0] in_up_re;
   logic signed [WIDTH-1:0] in_up_im;
   logic signed [WIDTH-1:0] in_l_re;
   logic signed [WIDTH-1:0] in_l_im;

   logic                    out_valid;
   logic                    out_half;
   logic [2:0]              out_idx;
   logic signed [WIDTH-1:0] out_up_re;
   logic signed [WIDTH-1:0] out_up_im;
   logic signed [WIDTH-1:0] out_l_re;
   logic signed [WIDTH-1:0] out_l_im;

   modport master (
      output in_valid, in_up_re, in_up_im, in_l_re, in_l_im,
      input  out_valid, out_half, out_idx,
      input  out_up_re, out_up_im, out_l_re, out_l_im
   );

   modport slave (
      input  in_valid, in_up_re, in_up_im, in_l_re, in_l_im,
      output out_valid, out_half, out_idx,
      output out_up_re, out_up_im, out_l_re, out_l_im
   );
endinterface

// File: rtl/fft_state2.sv
// Second stage of the 32-point radix-2 DIF MDC FFT: commutator, two 8-deep
// delay lines, one butterfly and a W16 twiddle multiply shared by both streams.
module fft_state2 #(
   parameter int WIDTH    = 9,
   parameter int TW_WIDTH = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   fft_state2_if.slave  bus
);
   localparam int D    = 8;
   localparam int XW   = WIDTH + 1;
   localparam int PW   = XW + TW_WIDTH + 1;
   localparam int FRAC = TW_WIDTH - 2;

   typedef enum logic {ST_FILL, ST_RUN} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       primed;

   logic signed [WIDTH-1:0] dl_re_q [D];
   logic signed [WIDTH-1:0] dl_im_q [D];
   logic signed [WIDTH-1:0] du_re_q [D];
   logic signed [WIDTH-1:0] du_im_q [D];

   logic signed [WIDTH-1:0] br_re, br_im;
   logic signed [WIDTH-1:0] bl_re, bl_im;
   logic signed [WIDTH-1:0] bu_re, bu_im;

   logic signed [XW-1:0] u_re_x, u_im_x, l_re_x, l_im_x;
   logic signed [XW-1:0] sum_re, sum_im, diff_re, diff_im;

   logic signed [TW_WIDTH-1:0] w_re, w_im;
   logic signed [PW-1:0]       mul_re, mul_im;

   logic                    out_valid_q, out_half_q;
   logic [2:0]              out_idx_q;
   logic signed [WIDTH-1:0] out_up_re_q, out_up_im_q, out_l_re_q, out_l_im_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The beat with cnt=8 is already primed even though the state flips after it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      primed  = (state_q == ST_RUN) || (cnt_q == 4'd8);
      if (bus.in_valid) begin
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'd8) begin
            state_d = ST_RUN;
         end
      end
   end

   always_comb begin
      bu_re = du_re_q[D-1];
      bu_im = du_im_q[D-1];
      if (cnt_q[3]) begin
         br_re = dl_re_q[D-1];
         br_im = dl_im_q[D-1];
         bl_re = bus.in_up_re;
         bl_im = bus.in_up_im;
      end else begin
         br_re = bus.in_up_re;
         br_im = bus.in_up_im;
         bl_re = dl_re_q[D-1];
         bl_im = dl_im_q[D-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < D; i++) begin
            dl_re_q[i] <= '0;
            dl_im_q[i] <= '0;
            du_re_q[i] <= '0;
            du_im_q[i] <= '0;
         end
      end else if (bus.in_valid) begin
         dl_re_q[0] <= bus.in_l_re;
         dl_im_q[0] <= bus.in_l_im;
         du_re_q[0] <= br_re;
         du_im_q[0] <= br_im;
         for (int unsigned i = 1; i < D; i++) begin
            dl_re_q[i] <= dl_re_q[i-1];
            dl_im_q[i] <= dl_im_q[i-1];
            du_re_q[i] <= du_re_q[i-1];
            du_im_q[i] <= du_im_q[i-1];
         end
      end
   end

   assign u_re_x  = {bu_re[WIDTH-1], bu_re};
   assign u_im_x  = {bu_im[WIDTH-1], bu_im};
   assign l_re_x  = {bl_re[WIDTH-1], bl_re};
   assign l_im_x  = {bl_im[WIDTH-1], bl_im};
   assign sum_re  = u_re_x + l_re_x;
   assign sum_im  = u_im_x + l_im_x;
   assign diff_re = u_re_x - l_re_x;
   assign diff_im = u_im_x - l_im_x;

   // W16^n in Q1.7, n taken from the low counter bits of the current beat.
   always_comb begin
      w_re = TW_WIDTH'(128);
      w_im = TW_WIDTH'(0);
      case (cnt_q[2:0])
         3'd0: begin w_re = TW_WIDTH'(128);  w_im = TW_WIDTH'(0);    end
         3'd1: begin w_re = TW_WIDTH'(118);  w_im = TW_WIDTH'(-49);  end
         3'd2: begin w_re = TW_WIDTH'(91);   w_im = TW_WIDTH'(-91);  end
         3'd3: begin w_re = TW_WIDTH'(49);   w_im = TW_WIDTH'(-118); end
         3'd4: begin w_re = TW_WIDTH'(0);    w_im = TW_WIDTH'(-128); end
         3'd5: begin w_re = TW_WIDTH'(-49);  w_im = TW_WIDTH'(-118); end
         3'd6: begin w_re = TW_WIDTH'(-91);  w_im = TW_WIDTH'(-91);  end
         3'd7: begin w_re = TW_WIDTH'(-118); w_im = TW_WIDTH'(-49);  end
         default: begin w_re = TW_WIDTH'(128); w_im = TW_WIDTH'(0);  end
      endcase
   end

   assign mul_re = PW'(diff_re) * PW'(w_re) - PW'(diff_im) * PW'(w_im);
   assign mul_im = PW'(diff_re) * PW'(w_im) + PW'(diff_im) * PW'(w_re);

   // Slicing at FRAC is the floor shift; bits above the window wrap away.
   logic unused_bits;
   assign unused_bits = ^{sum_re[WIDTH], sum_im[WIDTH],
                          mul_re[PW-1:FRAC+WIDTH], mul_re[FRAC-1:0],
                          mul_im[PW-1:FRAC+WIDTH], mul_im[FRAC-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_half_q  <= 1'b0;
         out_idx_q   <= '0;
         out_up_re_q <= '0;
         out_up_im_q <= '0;
         out_l_re_q  <= '0;
         out_l_im_q  <= '0;
      end else if (bus.in_valid) begin
         out_valid_q <= primed;
         out_half_q  <= ~cnt_q[3];
         out_idx_q   <= cnt_q[2:0];
         out_up_re_q <= sum_re[WIDTH-1:0];
         out_up_im_q <= sum_im[WIDTH-1:0];
         out_l_re_q  <= mul_re[FRAC +: WIDTH];
         out_l_im_q  <= mul_im[FRAC +: WIDTH];
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_half  = out_half_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_up_re = out_up_re_q;
   assign bus.out_up_im = out_up_im_q;
   assign bus.out_l_re  = out_l_re_q;
   assign bus.out_l_im  = out_l_im_q;
endmodule

// File: tb/tb_fft_state2.sv
// Self-checking bench for fft_state2: directed butterfly/twiddle cases plus
// random gapped streams against a frame-level reference model.
module tb_fft_state2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_state2_if #(.WIDTH(9)) bus();

   fft_state2 #(.WIDTH(9), .TW_WIDTH(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit found;
      bit half;
      int idx;
      int ure, uim, lre, lim;
   } ent_t;

   ent_t cap_q[$];
   ent_t exp_q[$];
   int   lg_ur[$], lg_ui[$], lg_lr[$], lg_li[$];
   int   fa_re[16], fa_im[16], fb_re[16], fb_im[16];
   int   TWR[8] = '{128, 118, 91, 49, 0, -49, -91, -118};
   int   TWI[8] = '{0, -49, -91, -118, -128, -118, -91, -49};
   int   checks = 0;
   int   errors = 0;

   always @(negedge clk) begin : monitor
      ent_t e;
      if (rst_n && bus.out_valid) begin
         e.found = 1'b1;
         e.half  = bus.out_half;
         e.idx   = int'(bus.out_idx);
         e.ure   = int'(bus.out_up_re);
         e.uim   = int'(bus.out_up_im);
         e.lre   = int'(bus.out_l_re);
         e.lim   = int'(bus.out_l_im);
         cap_q.push_back(e);
      end
   end

   function automatic int wrap9(int v);
      logic signed [8:0] s;
      s = v[8:0];
      return int'(s);
   endfunction

   // Beat k (k>=8) of the stream since reset: t=k%16 in 8..15 finishes the
   // a-pair of frame k/16; t in 0..7 finishes the b-pair of the previous frame.
   function automatic void build_exp();
      exp_q.delete();
      for (int k = 8; k < lg_ur.size(); k++) begin
         ent_t e;
         int t, n, base, ur, ui, lr, li, dr, di;
         t = k % 16;
         n = k % 8;
         if (t >= 8) begin
            base = 16 * (k / 16);
            ur = lg_ur[base + n];     ui = lg_ui[base + n];
            lr = lg_ur[base + n + 8]; li = lg_ui[base + n + 8];
            e.half = 1'b0;
         end else begin
            base = 16 * (k / 16 - 1);
            ur = lg_lr[base + n];     ui = lg_li[base + n];
            lr = lg_lr[base + n + 8]; li = lg_li[base + n + 8];
            e.half = 1'b1;
         end
         dr = ur - lr;
         di = ui - li;
         e.found = 1'b1;
         e.idx = n;
         e.ure = wrap9(ur + lr);
         e.uim = wrap9(ui + li);
         e.lre = wrap9((dr * TWR[n] - di * TWI[n]) >>> 7);
         e.lim = wrap9((dr * TWI[n] + di * TWR[n]) >>> 7);
         exp_q.push_back(e);
      end
   endfunction

   function automatic ent_t find(bit h, int n);
      ent_t e;
      e = '{found: 1'b0, half: 1'b0, idx: 0, ure: 0, uim: 0, lre: 0, lim: 0};
      for (int i = 0; i < cap_q.size(); i++) begin
         if (!e.found && cap_q[i].half == h && cap_q[i].idx == n) e = cap_q[i];
      end
      return e;
   endfunction

   task automatic drive(bit v, int ur, int ui, int lr, int li);
      bus.in_valid = v;
      bus.in_up_re = 9'(ur);
      bus.in_up_im = 9'(ui);
      bus.in_l_re  = 9'(lr);
      bus.in_l_im  = 9'(li);
      if (v) begin
         lg_ur.push_back(wrap9(ur));
         lg_ui.push_back(wrap9(ui));
         lg_lr.push_back(wrap9(lr));
         lg_li.push_back(wrap9(li));
      end
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd9();
      return int'($urandom_range(0, 511)) - 256;
   endfunction

   task automatic clear_logs();
      cap_q.delete();
      lg_ur.delete(); lg_ui.delete(); lg_lr.delete(); lg_li.delete();
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #3;
      clear_logs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 16; i++) begin
         fa_re[i] = 0; fa_im[i] = 0; fb_re[i] = 0; fb_im[i] = 0;
      end
   endtask

   task automatic send_frame_flush();
      for (int t = 0; t < 16; t++) drive(1'b1, fa_re[t], fa_im[t], fb_re[t], fb_im[t]);
      for (int t = 0; t < 8; t++) drive(1'b1, 0, 0, 0, 0);
      drive(1'b0, 0, 0, 0, 0);
      drive(1'b0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 20; i++) drive(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_valid got %0b exp 1", bus.out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_half, bus.out_idx} !== 5'd0) begin
         errors++;
         $display("FAIL reset_ctrl got v=%0b h=%0b i=%0d exp 0", bus.out_valid, bus.out_half, bus.out_idx);
      end
      checks++;
      if ({bus.out_up_re, bus.out_up_im, bus.out_l_re, bus.out_l_im} !== 36'd0) begin
         errors++;
         $display("FAIL reset_data got %0d %0d %0d %0d exp 0", bus.out_up_re, bus.out_up_im, bus.out_l_re, bus.out_l_im);
      end
      bus.in_valid = 1'b0;
      clear_logs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid beat %0d got %0b exp 0", i, bus.out_valid);
         end
      end
      drive(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
      checks++;
      if ({bus.out_valid, bus.out_half, bus.out_idx} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL first_valid got v=%0b h=%0b i=%0d exp v=1 h=0 i=0", bus.out_valid, bus.out_half, bus.out_idx);
      end
      for (int i = 0; i < 15; i++) drive(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
      drive(1'b0, 0, 0, 0, 0);
      checks++;
      if (cap_q.size() !== 16) begin
         errors++;
         $display("FAIL reset_frame_count got %0d exp 16", cap_q.size());
      end
   endtask

   task automatic test_impulse();
      ent_t e;
      int nz;
      do_reset();
      clear_frame();
      fa_re[0] = 64;
      send_frame_flush();
      e = find(1'b0, 0);
      checks++;
      if (!e.found || e.ure !== 64 || e.uim !== 0 || e.lre !== 64 || e.lim !== 0) begin
         errors++;
         $display("FAIL impulse_n0 got f=%0b up=(%0d,%0d) l=(%0d,%0d) exp up=(64,0) l=(64,0)", e.found, e.ure, e.uim, e.lre, e.lim);
      end
      nz = 0;
      foreach (cap_q[i]) begin
         if (!(cap_q[i].half == 1'b0 && cap_q[i].idx == 0) &&
             (cap_q[i].ure != 0 || cap_q[i].uim != 0 || cap_q[i].lre != 0 || cap_q[i].lim != 0)) nz++;
      end
      checks++;
      if (nz !== 0 || cap_q.size() !== 16) begin
         errors++;
         $display("FAIL impulse_others got nonzero=%0d count=%0d exp nonzero=0 count=16", nz, cap_q.size());
      end
   endtask

   task automatic test_twiddle();
      ent_t e;
      do_reset();
      clear_frame();
      fa_re[10] = 64;
      fa_re[12] = 64;
      send_frame_flush();
      e = find(1'b0, 2);
      checks++;
      if (!e.found || e.ure !== 64 || e.uim !== 0 || e.lre !== -46 || e.lim !== 45) begin
         errors++;
         $display("FAIL twiddle_n2 got f=%0b up=(%0d,%0d) l=(%0d,%0d) exp up=(64,0) l=(-46,45)", e.found, e.ure, e.uim, e.lre, e.lim);
      end
      e = find(1'b0, 4);
      checks++;
      if (!e.found || e.ure !== 64 || e.uim !== 0 || e.lre !== 0 || e.lim !== 64) begin
         errors++;
         $display("FAIL twiddle_n4 got f=%0b up=(%0d,%0d) l=(%0d,%0d) exp up=(64,0) l=(0,64)", e.found, e.ure, e.uim, e.lre, e.lim);
      end
   endtask

   task automatic test_lower();
      ent_t e;
      do_reset();
      clear_frame();
      fb_re[1] = 100;
      send_frame_flush();
      e = find(1'b1, 1);
      checks++;
      if (!e.found || e.ure !== 100 || e.uim !== 0 || e.lre !== 92 || e.lim !== -39) begin
         errors++;
         $display("FAIL lower_b1 got f=%0b up=(%0d,%0d) l=(%0d,%0d) exp up=(100,0) l=(92,-39)", e.found, e.ure, e.uim, e.lre, e.lim);
      end
   endtask

   task automatic test_wrap();
      ent_t e;
      do_reset();
      clear_frame();
      fa_re[0] = 255;
      fa_re[8] = 255;
      send_frame_flush();
      e = find(1'b0, 0);
      checks++;
      if (!e.found || e.ure !== -2 || e.uim !== 0 || e.lre !== 0 || e.lim !== 0) begin
         errors++;
         $display("FAIL wrap_n0 got f=%0b up=(%0d,%0d) l=(%0d,%0d) exp up=(-2,0) l=(0,0)", e.found, e.ure, e.uim, e.lre, e.lim);
      end
   endtask

   // Each round starts with a reset; all but the first land mid-frame.
   task automatic test_random_gaps();
      for (int r = 0; r < 4; r++) begin
         int nb;
         do_reset();
         nb = 40 + int'($urandom_range(0, 30));
         for (int b = 0; b < nb; b++) begin
            while ($urandom_range(0, 3) == 0) drive(1'b0, rnd9(), rnd9(), rnd9(), rnd9());
            drive(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
         end
         drive(1'b0, 0, 0, 0, 0);
         drive(1'b0, 0, 0, 0, 0);
         build_exp();
         checks++;
         if (cap_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count round %0d got %0d exp %0d", r, cap_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].half !== exp_q[i].half || cap_q[i].idx !== exp_q[i].idx ||
                cap_q[i].ure !== exp_q[i].ure || cap_q[i].uim !== exp_q[i].uim ||
                cap_q[i].lre !== exp_q[i].lre || cap_q[i].lim !== exp_q[i].lim) begin
               errors++;
               $display("FAIL rand_out r%0d #%0d got h=%0b i=%0d up=(%0d,%0d) l=(%0d,%0d) exp h=%0b i=%0d up=(%0d,%0d) l=(%0d,%0d)",
                        r, i, cap_q[i].half, cap_q[i].idx, cap_q[i].ure, cap_q[i].uim, cap_q[i].lre, cap_q[i].lim,
                        exp_q[i].half, exp_q[i].idx, exp_q[i].ure, exp_q[i].uim, exp_q[i].lre, exp_q[i].lim);
            end
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_up_re = '0;
      bus.in_up_im = '0;
      bus.in_l_re  = '0;
      bus.in_l_im  = '0;
      test_reset();
      test_impulse();
      test_twiddle();
      test_lower();
      test_wrap();
      test_random_gaps();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
